// File: rtl/act_frame_sequencer.sv
// Per-frame sequencer for an accelerator core: feeds input words, injects zero drain words,
// and buffers core outputs in a FIFO toward a backpressured consumer with overflow detection.
module act_frame_sequencer #(
  parameter int IN_W      = 48,
  parameter int OUT_W     = 4096,
  parameter int CNT_W     = 16,
  parameter int OUT_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_frame_len,
  input  logic [CNT_W-1:0] cfg_drain_len,
  input  logic             s_valid,
  input  logic [IN_W-1:0]  s_data,
  output logic             s_ready,
  output logic             core_valid,
  output logic [IN_W-1:0]  core_act,
  input  logic [OUT_W-1:0] core_out,
  input  logic             core_ready,
  output logic             m_valid,
  output logic [OUT_W-1:0] m_data,
  input  logic             m_ready,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] out_count,
  output logic             overflow
);

  localparam int AW = $clog2(OUT_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    FEED,
    DRAIN,
    FLUSH,
    DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [CNT_W-1:0]  r_frame_len;
  logic [CNT_W-1:0]  r_drain_len;
  logic [CNT_W-1:0]  r_in_cnt;
  logic [CNT_W-1:0]  r_drain_cnt;
  logic [CNT_W-1:0]  r_out_count;
  logic              r_core_valid;
  logic [IN_W-1:0]   r_core_act;
  logic              r_overflow;

  logic [OUT_W-1:0]  r_mem [OUT_DEPTH];
  logic [AW:0]       r_wptr;
  logic [AW:0]       r_rptr;

  logic              w_abort;
  logic              w_start_ok;
  logic              w_s_ready;
  logic              w_xfer;
  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_store;
  logic              w_drop;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push  = core_ready;
  assign w_pop   = !w_empty && m_ready;
  assign w_store = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  assign w_abort = abort && (r_state != IDLE);
  assign w_xfer  = w_s_ready && s_valid;

  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    w_s_ready   = 1'b0;
    if (w_abort) begin
      w_state_nxt = IDLE;
      w_s_ready   = (r_state == FEED);
    end else begin
      case (r_state)
        IDLE: begin
          if (start && !abort && (cfg_frame_len != '0)) begin
            w_start_ok  = 1'b1;
            w_state_nxt = FEED;
          end
        end
        FEED: begin
          w_s_ready = 1'b1;
          if (s_valid && (r_in_cnt == r_frame_len - CNT_W'(1))) begin
            w_state_nxt = (r_drain_len != '0) ? DRAIN : FLUSH;
          end
        end
        DRAIN: begin
          if (r_drain_cnt == r_drain_len - CNT_W'(1)) begin
            w_state_nxt = FLUSH;
          end
        end
        FLUSH: begin
          if (w_empty && !w_push) begin
            w_state_nxt = DONE;
          end
        end
        DONE:    w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_frame_len  <= '0;
      r_drain_len  <= '0;
      r_in_cnt     <= '0;
      r_drain_cnt  <= '0;
      r_core_valid <= 1'b0;
      r_core_act   <= '0;
      r_out_count  <= '0;
      r_overflow   <= 1'b0;
      r_wptr       <= '0;
      r_rptr       <= '0;
    end else begin
      if (w_start_ok) begin
        r_frame_len <= cfg_frame_len;
        r_drain_len <= cfg_drain_len;
        r_in_cnt    <= '0;
        r_drain_cnt <= '0;
      end else begin
        if (w_xfer) begin
          r_in_cnt <= r_in_cnt + CNT_W'(1);
        end
        if (r_state == DRAIN) begin
          r_drain_cnt <= r_drain_cnt + CNT_W'(1);
        end
      end

      // A word accepted in the abort cycle is discarded rather than forwarded.
      if (w_abort) begin
        r_core_valid <= 1'b0;
      end else if (r_state == FEED) begin
        r_core_valid <= s_valid;
        if (s_valid) begin
          r_core_act <= s_data;
        end
      end else if (r_state == DRAIN) begin
        r_core_valid <= 1'b1;
        r_core_act   <= '0;
      end else begin
        r_core_valid <= 1'b0;
      end

      // A capture in the start cycle counts toward the new frame.
      if (w_start_ok) begin
        r_out_count <= w_push ? CNT_W'(1) : '0;
        r_overflow  <= w_drop;
      end else begin
        if (w_push && (r_out_count != '1)) begin
          r_out_count <= r_out_count + CNT_W'(1);
        end
        if (w_drop) begin
          r_overflow <= 1'b1;
        end
      end

      if (w_store) begin
        r_wptr <= r_wptr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && w_store) begin
      r_mem[r_wptr[AW-1:0]] <= core_out;
    end
  end

  assign s_ready    = w_s_ready;
  assign core_valid = r_core_valid;
  assign core_act   = r_core_act;
  assign m_valid    = !w_empty;
  assign m_data     = r_mem[r_rptr[AW-1:0]];
  assign busy       = (r_state != IDLE);
  assign frame_done = (r_state == DONE);
  assign out_count  = r_out_count;
  assign overflow   = r_overflow;

endmodule
